// File: rtl/simple_single_port_ram_pkg.sv
// Shared constants, types and parity helper for simple_single_port_ram.
// The optional parity path is enabled with the SSRAM_PARITY_EN macro.
package simple_single_port_ram_pkg;

  localparam int ADDR_W_DEF = 7;
  localparam int DATA_W_DEF = 8;
  localparam int DEPTH_DEF  = 2 ** ADDR_W_DEF;

  typedef logic [ADDR_W_DEF-1:0] addr_t;
  typedef logic [DATA_W_DEF-1:0] data_t;

  // Even parity: the stored bit makes the total count of ones even.
  function automatic logic parity_f(input data_t data);
    return ^data;
  endfunction

endpackage

// File: rtl/simple_single_port_ram_parity_gen.sv
// Parity generation (write side) and check (read side) for simple_single_port_ram.
// Only compiled into the design when SSRAM_PARITY_EN is defined.
`ifdef SSRAM_PARITY_EN
module ssram_parity_gen
  import simple_single_port_ram_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_par,
  input  logic [DATA_W-1:0] rd_word,
  input  logic              rd_par,
  output logic              rd_err
);

  assign wr_par = ^wr_data;
  assign rd_err = rd_par ^ (^rd_word);

endmodule
`endif

// File: rtl/simple_single_port_ram.sv
// 2**ADDR_W x DATA_W single-port RAM, registered read, read-first on collision.
// Define SSRAM_PARITY_EN to add per-word even parity and the rd_par_err_o output.
module simple_single_port_ram
  import simple_single_port_ram_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEF,
  parameter int DATA_W = DATA_W_DEF
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              wr_en_i,
  input  logic              rd_en_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [DATA_W-1:0] wr_data_i,
`ifdef SSRAM_PARITY_EN
  output logic              rd_par_err_o,
`endif
  output logic [DATA_W-1:0] rd_data_o
);

  localparam int DEPTH = 2 ** ADDR_W;

  logic [DATA_W-1:0] mem_reg [DEPTH];
  logic [DATA_W-1:0] rd_data_reg;

  // Reset clears the whole array, so every word needs its own clear path.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_data_reg <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_reg[i] <= '0;
      end
    end else begin
      if (wr_en_i) begin
        mem_reg[addr_i] <= wr_data_i;
      end
      if (rd_en_i) begin
        rd_data_reg <= mem_reg[addr_i];
      end
    end
  end

  assign rd_data_o = rd_data_reg;

`ifdef SSRAM_PARITY_EN
  logic par_reg [DEPTH];
  logic rd_par_err_reg;
  logic wr_par_next;
  logic rd_err_next;

  ssram_parity_gen #(
    .DATA_W (DATA_W)
  ) u_parity (
    .wr_data (wr_data_i),
    .wr_par  (wr_par_next),
    .rd_word (mem_reg[addr_i]),
    .rd_par  (par_reg[addr_i]),
    .rd_err  (rd_err_next)
  );

  // Check uses the pre-write word and parity, matching the read-first data path.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_par_err_reg <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        par_reg[i] <= 1'b0;
      end
    end else begin
      if (wr_en_i) begin
        par_reg[addr_i] <= wr_par_next;
      end
      if (rd_en_i) begin
        rd_par_err_reg <= rd_err_next;
      end
    end
  end

  assign rd_par_err_o = rd_par_err_reg;
`endif

endmodule

// File: tb/tb_simple_single_port_ram.sv
// Self-checking bench for simple_single_port_ram: directed scenarios plus random
// traffic against an array-based reference model. Honours SSRAM_PARITY_EN.
module tb_simple_single_port_ram;

  localparam int AW    = 7;
  localparam int DW    = 8;
  localparam int DEPTH = 128;

  logic          clk_i;
  logic          rst_i;
  logic          wr_en_i;
  logic          rd_en_i;
  logic [AW-1:0] addr_i;
  logic [DW-1:0] wr_data_i;
  logic [DW-1:0] rd_data_o;
`ifdef SSRAM_PARITY_EN
  logic          rd_par_err_o;
`endif

  simple_single_port_ram #(
    .ADDR_W (AW),
    .DATA_W (DW)
  ) dut (
    .clk_i     (clk_i),
    .rst_i     (rst_i),
    .wr_en_i   (wr_en_i),
    .rd_en_i   (rd_en_i),
    .addr_i    (addr_i),
    .wr_data_i (wr_data_i),
`ifdef SSRAM_PARITY_EN
    .rd_par_err_o (rd_par_err_o),
`endif
    .rd_data_o (rd_data_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  // Reference model: plain arrays updated by the access rules.
  logic [DW-1:0] ref_mem [DEPTH];
  logic          ref_par [DEPTH];
  logic [DW-1:0] ref_rd;
  logic          ref_err;

  int checks_cnt;
  int errors_cnt;
  int txn_cnt;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks_cnt++;
    if (got !== exp) begin
      errors_cnt++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Apply one access for one edge, update the model, then compare outputs.
  task automatic cycle(input logic rst, input logic we, input logic re,
                       input logic [AW-1:0] a, input logic [DW-1:0] d, input string tag);
    logic [DW-1:0] old_word;
    logic          old_par;
    rst_i = rst; wr_en_i = we; rd_en_i = re; addr_i = a; wr_data_i = d;
    @(posedge clk_i);
    if (rst) begin
      ref_rd  = '0;
      ref_err = 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        ref_mem[i] = '0;
        ref_par[i] = 1'b0;
      end
    end else begin
      old_word = ref_mem[a];
      old_par  = ref_par[a];
      if (we) begin
        ref_mem[a] = d;
        ref_par[a] = ^d;
      end
      if (re) begin
        ref_rd  = old_word;
        ref_err = (old_par != (^old_word));
      end
    end
    #1;
    txn_cnt++;
    $display("txn %0d %s rst=%0b we=%0b re=%0b addr=0x%02h wd=0x%02h rd=0x%02h",
             txn_cnt, tag, rst, we, re, a, d, rd_data_o);
    check_val({tag, "_rd"}, 32'(rd_data_o), 32'(ref_rd));
`ifdef SSRAM_PARITY_EN
    check_val({tag, "_perr"}, 32'(rd_par_err_o), 32'(ref_err));
`endif
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic          r_rst, r_we, r_re;
    logic [AW-1:0] r_a;
    logic [DW-1:0] r_d;
    checks_cnt = 0;
    errors_cnt = 0;
    txn_cnt    = 0;
    ref_rd     = 'x;
    ref_err    = 'x;
    rst_i = 1'b1; wr_en_i = 1'b0; rd_en_i = 1'b0; addr_i = '0; wr_data_i = '0;

    // Reset with a write pending: the write must be ignored.
    cycle(1, 1, 0, 7'h04, 8'h99, "rst0");
    cycle(1, 1, 0, 7'h04, 8'h99, "rst1");
    check_val("rst_state", 32'(rd_data_o), 32'h00);
    cycle(0, 0, 1, 7'h04, 8'h00, "rst_rd04");
    check_val("rst_rd04_const", 32'(rd_data_o), 32'h00);

    // Basic write/read.
    cycle(0, 1, 0, 7'h04, 8'h45, "wr04");
    cycle(0, 1, 0, 7'h05, 8'h22, "wr05");
    cycle(0, 0, 1, 7'h04, 8'h00, "rd04");
    check_val("basic_rd04", 32'(rd_data_o), 32'h45);
`ifdef SSRAM_PARITY_EN
    check_val("par_ok", 32'(rd_par_err_o), 32'h0);
`endif
    cycle(0, 0, 1, 7'h05, 8'h00, "rd05");
    check_val("basic_rd05", 32'(rd_data_o), 32'h22);

    // Hold with read disabled.
    for (int i = 0; i < 3; i++) begin
      cycle(0, 0, 0, 7'h04, 8'h00, "hold");
      check_val("hold_const", 32'(rd_data_o), 32'h22);
    end

    // Read-first collision.
    cycle(0, 1, 0, 7'h10, 8'hA5, "wr10");
    cycle(0, 1, 1, 7'h10, 8'h3C, "coll10");
    check_val("coll_old", 32'(rd_data_o), 32'hA5);
    cycle(0, 0, 1, 7'h10, 8'h00, "rd10");
    check_val("coll_new", 32'(rd_data_o), 32'h3C);

    // Address boundaries.
    cycle(0, 1, 0, 7'h7F, 8'hFF, "wr7f");
    cycle(0, 1, 0, 7'h00, 8'h01, "wr00");
    cycle(0, 0, 1, 7'h7F, 8'h00, "rd7f");
    check_val("bound_7f", 32'(rd_data_o), 32'hFF);
    cycle(0, 0, 1, 7'h00, 8'h00, "rd00");
    check_val("bound_00", 32'(rd_data_o), 32'h01);

    // Reset in the middle of a read stream.
    cycle(0, 0, 1, 7'h7F, 8'h00, "stream7f");
    cycle(1, 0, 1, 7'h00, 8'h00, "midrst");
    check_val("midrst_rd", 32'(rd_data_o), 32'h00);
    cycle(0, 0, 1, 7'h7F, 8'h00, "post7f");
    check_val("post_7f", 32'(rd_data_o), 32'h00);
    cycle(0, 0, 1, 7'h00, 8'h00, "post00");
    check_val("post_00", 32'(rd_data_o), 32'h00);

`ifdef SSRAM_PARITY_EN
    // Corrupt one stored bit behind the RAM's back; the read must flag it.
    cycle(0, 1, 0, 7'h20, 8'h45, "wr20");
    dut.mem_reg[7'h20] = dut.mem_reg[7'h20] ^ 8'h04;
    ref_mem[7'h20]     = ref_mem[7'h20] ^ 8'h04;
    cycle(0, 0, 1, 7'h20, 8'h00, "rd20bad");
    check_val("par_flip", 32'(rd_par_err_o), 32'h1);
    cycle(0, 1, 0, 7'h20, 8'h45, "fix20");
    cycle(0, 0, 1, 7'h20, 8'h00, "rd20ok");
    check_val("par_clear", 32'(rd_par_err_o), 32'h0);
`endif

    // Random traffic concentrated on a few addresses to force reuse and collisions.
    for (int n = 0; n < 1500; n++) begin
      r_rst = ($urandom_range(0, 199) == 0);
      r_we  = $urandom_range(0, 1);
      r_re  = $urandom_range(0, 1);
      r_a   = ($urandom_range(0, 3) == 0) ? AW'($urandom) : AW'($urandom_range(0, 7));
      r_d   = DW'($urandom);
      cycle(r_rst, r_we, r_re, r_a, r_d, "rnd");
    end

    // Sweep every address so persistence of random writes is confirmed.
    for (int i = 0; i < DEPTH; i++) begin
      cycle(0, 0, 1, AW'(i), 8'h00, "sweep");
    end

    $display("Simulation finished: %0d checks, %0d errors", checks_cnt, errors_cnt);
    $finish;
  end

endmodule
